// File: rtl/posit_dot_seq.sv
// Posit dot-product sequencer: streams element pairs into an external
// A*B + C*D posit core, one operation in flight. Each partial sum is fed back
// as C with D = ONE(mode), and the finished sum and element count are held
// until the consumer takes them.
module posit_dot_seq #(
  parameter int unsigned CORE_LAT = 6,
  parameter int unsigned MAXLEN   = 256,
  parameter int unsigned CW       = $clog2(MAXLEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    cfg_pre,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_a,
  input  logic [31:0]   in_b,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic [CW-1:0] out_count,
  output logic          err_len,
  output logic          core_start,
  output logic [31:0]   core_a,
  output logic [31:0]   core_b,
  output logic [31:0]   core_c,
  output logic [31:0]   core_d,
  output logic [1:0]    core_pre,
  input  logic [31:0]   core_res,
  output logic          busy
);

  localparam int unsigned DW = 32;
  // Latency counter must hold CORE_LAT and never collapse to zero width
  localparam int unsigned LW = $clog2(CORE_LAT + 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACC  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  // Packed posit 1.0 in every lane for the selected precision mode
  function automatic logic [DW-1:0] one_of(input logic [1:0] mode);
    logic [DW-1:0] v;
    case (mode)
      2'b01:   v = 32'h4000_4000;
      2'b10:   v = 32'h4040_4040;
      default: v = 32'h4000_0000;
    endcase
    return v;
  endfunction

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_accept;
  logic            w_capture;
  logic            w_len_err;
  logic            w_last_eff;
  logic [CW-1:0]   w_cnt_new;

  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_busy;
  logic            r_err;
  logic            r_last;
  logic [LW-1:0]   r_lat;
  logic [CW-1:0]   r_count;
  logic [DW-1:0]   r_acc;
  logic [1:0]      r_pre;
  logic            r_core_start;
  logic [DW-1:0]   r_core_a;
  logic [DW-1:0]   r_core_b;
  logic [DW-1:0]   r_core_c;
  logic [DW-1:0]   r_core_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, element acceptance, result capture and length-overflow detect
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_cnt_new   = r_count;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_cnt_new   = CW'(1);
          w_state_nxt = S_WAIT;
        end
      end
      S_ACC: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_cnt_new   = r_count + CW'(1);
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_lat == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = r_last ? S_HOLD : S_ACC;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // An element that fills the vector without in_last closes it anyway
    w_len_err  = w_accept && !in_last && (w_cnt_new == CW'(MAXLEN));
    w_last_eff = in_last || w_len_err;
  end

  // Handshake flags registered from the next state so they track the FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_ACC);
      r_out_valid <= (w_state_nxt == S_HOLD);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  // Core issue: operands and one-cycle start pulse registered off the handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_core_start <= 1'b0;
      r_core_a     <= '0;
      r_core_b     <= '0;
      r_core_c     <= '0;
      r_core_d     <= '0;
      r_pre        <= 2'b00;
    end else begin
      r_core_start <= w_accept;
      if (w_accept) begin
        r_core_a <= in_a;
        r_core_b <= in_b;
        if (r_state == S_IDLE) begin
          r_pre    <= cfg_pre;
          r_core_c <= '0;
          r_core_d <= '0;
        end else begin
          r_core_c <= r_acc;
          r_core_d <= one_of(r_pre);
        end
      end
    end
  end

  // Latency countdown, accumulator capture, element count and sticky length error
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lat   <= '0;
      r_last  <= 1'b0;
      r_count <= '0;
      r_acc   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_lat   <= LW'(CORE_LAT);
        r_last  <= w_last_eff;
        r_count <= w_cnt_new;
      end else if ((r_state == S_WAIT) && (r_lat != '0)) begin
        r_lat <= r_lat - LW'(1);
      end
      if (w_capture) begin
        r_acc <= core_res;
      end
      if (w_len_err) begin
        r_err <= 1'b1;
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_acc;
  assign out_count  = r_count;
  assign err_len    = r_err;
  assign busy       = r_busy;
  assign core_start = r_core_start;
  assign core_a     = r_core_a;
  assign core_b     = r_core_b;
  assign core_c     = r_core_c;
  assign core_d     = r_core_d;
  assign core_pre   = r_pre;

endmodule
